// File: rtl/bram_fill_ctrl.sv
// bram_fill_ctrl: captures a fixed-length burst from a valid/ready stream
// into consecutive BRAM words starting at address 0. The write port is
// registered, so every accepted beat appears on pl_* one cycle later.
module bram_fill_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              clear,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] pl_addr,
    output logic [DATA_W-1:0] pl_din,
    output logic              pl_en,
    output logic              pl_wr_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] len_q;
    logic              accept;
    logic              last_beat;
    logic              restart;

    // Status and handshake are plain decodes of the registered state, so
    // s_ready never depends on s_valid.
    assign s_ready   = (state_q == S_FILL);
    assign busy      = (state_q == S_FILL);
    assign done      = (state_q == S_DONE);
    assign accept    = s_valid && s_ready;
    assign last_beat = accept && (wr_ptr_q == len_q);
    // A start is honoured only outside FILL, and clear always wins over it.
    assign restart   = start && !clear && (state_q != S_FILL);

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)     state_d = S_FILL;
            S_FILL:  if (last_beat) state_d = S_DONE;
            S_DONE:  if (start)     state_d = S_FILL;
            default:                state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in every clocked block so all
        // registers update together from pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill length, write pointer and word counter; the pointer wraps at
    // full depth while the counter has one extra bit to reach 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            wr_ptr_q   <= '0;
            word_count <= '0;
        end else if (restart) begin
            len_q      <= len_m1;
            wr_ptr_q   <= '0;
            word_count <= '0;
        end else if (accept) begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            word_count <= word_count + 1'b1;
        end
    end

    // Registered BRAM write port: enables pulse for one cycle per accepted
    // beat, address and data hold their last values between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pl_en    <= 1'b0;
            pl_wr_en <= 1'b0;
            pl_addr  <= '0;
            pl_din   <= '0;
        end else begin
            pl_en    <= accept;
            pl_wr_en <= accept;
            if (accept) begin
                pl_addr <= wr_ptr_q;
                pl_din  <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// Testbench for bram_fill_ctrl: a driver applies directed and random cycles
// and predicts BRAM writes into a queue; a monitor compares the write port.
module tb_bram_fill_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] len_m1;
    logic              clear;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_din;
    logic              pl_en;
    logic              pl_wr_en;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    bram_fill_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len_m1(len_m1), .clear(clear),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .pl_addr(pl_addr), .pl_din(pl_din), .pl_en(pl_en), .pl_wr_en(pl_wr_en),
        .busy(busy), .done(done), .word_count(word_count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef enum {M_IDLE, M_FILL, M_DONE} mode_t;

    wr_t               exp_q[$];
    int                errors = 0;
    int                checks = 0;
    mode_t             mode   = M_IDLE;
    int                m_len  = 0;
    int                m_cnt  = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [DATA_W-1:0] hold_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: check status from the last edge, drive inputs,
    // then advance the abstract model across the coming edge.
    task automatic cyc(input bit r, input bit st, input int len, input bit cl,
                       input bit v, input logic [DATA_W-1:0] d);
        bit acc;
        @(negedge clk);
        check("s_ready", s_ready, mode == M_FILL);
        check("busy", busy, mode == M_FILL);
        check("done", done, mode == M_DONE);
        check("word_count", word_count, m_cnt);
        rst     = r;
        start   = st;
        len_m1  = len[ADDR_W-1:0];
        clear   = cl;
        s_valid = v;
        s_data  = d;
        if (r) begin
            mode      = M_IDLE;
            m_cnt     = 0;
            m_len     = 0;
            hold_addr = '0;
            hold_data = '0;
        end else begin
            acc = (mode == M_FILL) && v;
            if (acc) begin
                exp_q.push_back('{addr: ADDR_W'(m_cnt % DEPTH), data: d});
                m_cnt++;
            end
            if (cl) begin
                mode = M_IDLE;
            end else if (mode != M_FILL && st) begin
                mode  = M_FILL;
                m_len = len % DEPTH;
                m_cnt = 0;
            end else if (acc && m_cnt == m_len + 1) begin
                mode = M_DONE;
            end
        end
    endtask

    // Write-port monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        wr_t e;
        bit  want;
        #1;
        want = (exp_q.size() > 0);
        check("pl_en", pl_en, want);
        check("pl_wr_en", pl_wr_en, want);
        if (want) begin
            e = exp_q.pop_front();
            if (pl_en) begin
                check("pl_addr", pl_addr, e.addr);
                check("pl_din", pl_din, e.data);
                hold_addr = e.addr;
                hold_data = e.data;
            end
        end else begin
            check("pl_addr_hold", pl_addr, hold_addr);
            check("pl_din_hold", pl_din, hold_data);
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; len_m1 = '0; clear = 1'b0;
        s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);

        // Basic fill of four words.
        cyc(0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'hA0 + i);
        repeat (2) cyc(0, 0, 0, 0, 1, 32'hEE);

        // Alternating valid gaps over eight words.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, (i % 2) == 0, 32'hB00 + i);

        // Full-depth fill, then stream keeps pushing while done.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 15, 0, 0, 0);
        for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, 1, 32'hC00 + i);

        // Abort after five beats, then a short fill.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'hD00 + i);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'hD10 + i);

        // Clear in the same cycle as an accepted beat.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h111);
        cyc(0, 1, 0, 1, 1, 32'h222);
        cyc(0, 0, 0, 0, 1, 32'h333);

        // Start ignored during FILL, then reset mid-fill.
        cyc(0, 1, 9, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hE00);
        cyc(0, 0, 0, 0, 1, 32'hE01);
        cyc(0, 1, 0, 0, 1, 32'hE02);
        cyc(1, 0, 0, 0, 1, 32'hE03);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 32'hE10 + i);

        // Restart directly from DONE.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hF00);
        cyc(0, 0, 0, 0, 1, 32'hF01);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'hF10 + i);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, DEPTH - 1), $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) < 7, $urandom);
        end

        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_fill_ctrl.md
BRAM_FILL_CTRL -- requirements
Module: bram_fill_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of stream data and BRAM write data.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning BRAM address width (depth 2^ADDR_W words).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a fill.
REQ-006 SHALL have port len_m1  input  ADDR_W  word count minus one, sampled on accepted start.
REQ-007 SHALL have port clear  input  1  abort/acknowledge; returns block to IDLE.
REQ-008 SHALL have port s_data  input  DATA_W  stream write data.
REQ-009 SHALL have port s_valid  input  1  stream data valid.
REQ-010 SHALL have port s_ready  output  1  block accepts stream data.
REQ-011 SHALL have port pl_addr  output  ADDR_W  BRAM write address.
REQ-012 SHALL have port pl_din  output  DATA_W  BRAM write data.
REQ-013 SHALL have port pl_en  output  1  BRAM enable.
REQ-014 SHALL have port pl_wr_en  output  1  BRAM write enable.
REQ-015 SHALL have port busy  output  1  high in FILL.
REQ-016 SHALL have port done  output  1  level; buffer filled, consumer may read.
REQ-017 SHALL have port word_count  output  ADDR_W+1  words written in current/last fill.

Function
REQ-018 SHALL implement FSM states IDLE, FILL, DONE; busy=(state==FILL), done=(state==DONE), both registered-state decodes.
REQ-019 IDLE: start=1 -> latch len_m1, clear word_count and write pointer to 0, go FILL next cycle.
REQ-020 s_ready SHALL equal (state==FILL) combinationally from state only; no dependency on s_valid.
REQ-021 Beat accepted when s_valid&s_ready; on accept, next cycle pl_en=1, pl_wr_en=1, pl_addr=write pointer, pl_din=s_data (one-cycle registered latency).
REQ-022 No accept in a cycle -> next cycle pl_en=0, pl_wr_en=0; pl_addr/pl_din hold previous values.
REQ-023 Each accept SHALL increment write pointer and word_count by 1; pointer wraps modulo 2^ADDR_W.
REQ-024 Accept with pointer==latched len_m1 SHALL be last beat: go DONE next cycle; s_ready low from that cycle.
REQ-025 len_m1=2^ADDR_W-1 SHALL fill full depth; word_count reaches 2^ADDR_W without overflow (ADDR_W+1 bits).
REQ-026 DONE: hold done=1 and word_count until clear (-> IDLE) or start (-> FILL, re-latch len_m1, counters zeroed).
REQ-027 start in FILL SHALL be ignored.
REQ-028 clear in any state SHALL go IDLE next cycle; clear has priority over start and over a same-cycle accept's state transition; a beat accepted in that cycle is still written (REQ-021) and counted.
REQ-029 Stalls (s_valid=0 in FILL) SHALL be tolerated indefinitely; no timeout.

Reset
REQ-030 rst=1 on a rising edge SHALL force state IDLE, pl_addr=0, pl_din=0, pl_en=0, pl_wr_en=0, word_count=0, pointer=0, latched len=0; priority over all inputs.
REQ-031 rst mid-FILL SHALL abandon the fill; no BRAM write in the cycle after rst; done stays 0 until a later full fill.
REQ-032 Outputs after reset SHALL be: s_ready=0, busy=0, done=0.

Verification
REQ-033 Basic: rst, start with len_m1=3, s_valid held high with data 0xA0..0xA3 -> writes at addr 0..3 on 4 consecutive cycles starting 2 cycles after start, done=1 after last write, word_count=4.
REQ-034 Backpressure gaps: len_m1=7, s_valid toggling 1,0,1,0... -> exactly 8 writes, addr 0..7 contiguous, pl_en low in gap cycles, data order preserved.
REQ-035 Full depth: ADDR_W=4, len_m1=15 -> 16 writes addr 0..15, word_count=16, then done; s_ready=0 thereafter.
REQ-036 Abort/restart: start len_m1=9, clear after 5 accepts -> IDLE, word_count=5, done=0; new start len_m1=1 -> writes at addr 0,1 then done.
REQ-037 Reset mid-fill and ignored start: start in FILL does not restart pointer; rst asserted at beat 3 -> all outputs zero next cycle, no further writes.
REQ-038 DONE restart: in DONE assert start with len_m1=2 -> done drops next cycle, 3 writes at addr 0..2, done again.
